// File: rtl/positaccum_raw_mc_if.sv
// Handshake bundle between a term producer and the multi-channel raw-posit
// accumulator: input beat channel plus result strobe channel.
interface positaccum_raw_mc_if #(
  parameter int SBITS     = 9,
  parameter int FBITS_IN  = 56,
  parameter int FBITS_ACC = 120,
  parameter int CHANNELS  = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [CW-1:0]               in_chan;
  logic                        in_last;
  logic [SBITS+FBITS_IN+2:0]   in_data;
  logic                        out_valid;
  logic [CW-1:0]               out_chan;
  logic [SBITS+FBITS_ACC+2:0]  out_data;
  logic                        out_truncated;

  modport master (
    output in_valid, in_chan, in_last, in_data,
    input  in_ready, out_valid, out_chan, out_data, out_truncated
  );

  modport slave (
    input  in_valid, in_chan, in_last, in_data,
    output in_ready, out_valid, out_chan, out_data, out_truncated
  );
endinterface

// File: rtl/positaccum_raw_mc.sv
// Multi-channel accumulator of unpacked posit terms. One beat per cycle flows
// through a 4-stage align/add/normalise datapath; each channel keeps its own
// running sum and sticky truncation flag. A same-channel beat is held off
// until its predecessor has written back.
module positaccum_raw_mc #(
  parameter int SBITS     = 9,
  parameter int FBITS_IN  = 56,
  parameter int FBITS_ACC = 120,
  parameter int CHANNELS  = 4
) (
  input logic                clk,
  input logic                rst,
  positaccum_raw_mc_if.slave bus
);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OW   = SBITS + FBITS_ACC + 3;
  localparam int MW   = FBITS_ACC + 3;   // {hidden, fraction, 2 guard bits}
  localparam int SW   = FBITS_ACC + 4;   // MW plus carry
  localparam int SMAX = (1 << (SBITS - 1)) - 1;

  typedef struct packed {
    logic             sgn;
    logic [SBITS-1:0] scale;
    logic [FBITS_ACC-1:0] frac;
    logic             inf;
    logic             zero;
    logic             trunc;
  } acc_t;

  typedef struct packed {
    logic v; logic [CW-1:0] chan; logic last;
    logic hs; logic [SBITS-1:0] hsc; logic [MW-1:0] hm;
    logic ls; logic [SBITS-1:0] lsc; logic [MW-1:0] lm;
    logic inf; logic trunc;
  } s1_t;

  typedef struct packed {
    logic v; logic [CW-1:0] chan; logic last;
    logic hs; logic ls; logic [SBITS-1:0] hsc;
    logic [MW-1:0] hm; logic [MW-1:0] lm;
    logic inf; logic trunc;
  } s2_t;

  typedef struct packed {
    logic v; logic [CW-1:0] chan; logic last;
    logic sgn; logic [SBITS-1:0] sc; logic [SW-1:0] sum;
    logic inf; logic trunc;
  } s3_t;

  localparam acc_t ACC_ZERO = '{sgn: 1'b0, scale: '0, frac: '0, inf: 1'b0, zero: 1'b1, trunc: 1'b0};

  acc_t acc_q [CHANNELS];
  s1_t  p1_q, p1_d;
  s2_t  p2_q, p2_d;
  s3_t  p3_q, p3_d;
  acc_t res;

  logic             out_valid_q;
  logic [CW-1:0]    out_chan_q;
  logic [OW-1:0]    out_data_q;
  logic             out_trunc_q;

  logic                 in_sgn, in_inf, in_zero;
  logic [SBITS-1:0]     in_scale;
  logic [FBITS_IN-1:0]  in_frac;
  logic                 hazard, accept;

  acc_t                 a_rd;
  logic [FBITS_ACC-1:0] b_frac;
  logic [MW-1:0]        a_m, b_m;
  logic                 a_hi;

  logic signed [SBITS:0] d_s;
  int                    shamt;
  logic [2*MW-1:0]       wide;

  int                    lz, nsc;
  logic                  found, ntr;
  logic [MW-2:0]         nf;

  assign in_sgn   = bus.in_data[SBITS+FBITS_IN+2];
  assign in_scale = bus.in_data[SBITS+FBITS_IN+1 -: SBITS];
  assign in_frac  = bus.in_data[FBITS_IN+1 -: FBITS_IN];
  assign in_inf   = bus.in_data[1];
  assign in_zero  = bus.in_data[0];

  // Same-channel hazard against beats that have not yet written back.
  always_comb begin
    hazard = (p1_q.v && (p1_q.chan == bus.in_chan)) ||
             (p2_q.v && (p2_q.chan == bus.in_chan)) ||
             (p3_q.v && (p3_q.chan == bus.in_chan));
  end

  assign bus.in_ready = ~(bus.in_valid & hazard);
  assign accept       = bus.in_valid & bus.in_ready;

  // S0: read the channel sum, order the two operands by magnitude.
  always_comb begin
    a_rd   = acc_q[bus.in_chan];
    b_frac = '0;
    b_frac[FBITS_ACC-1 -: FBITS_IN] = in_frac;
    a_m = a_rd.zero ? '0 : {1'b1, a_rd.frac, 2'b00};
    b_m = in_zero   ? '0 : {1'b1, b_frac, 2'b00};
    if (in_zero)        a_hi = 1'b1;
    else if (a_rd.zero) a_hi = 1'b0;
    else a_hi = ($signed(a_rd.scale) > $signed(in_scale)) ||
                ((a_rd.scale == in_scale) && (a_rd.frac >= b_frac));
    p1_d       = '0;
    p1_d.v     = accept;
    p1_d.chan  = bus.in_chan;
    p1_d.last  = bus.in_last;
    p1_d.hs    = a_hi ? a_rd.sgn   : in_sgn;
    p1_d.hsc   = a_hi ? a_rd.scale : in_scale;
    p1_d.hm    = a_hi ? a_m        : b_m;
    p1_d.ls    = a_hi ? in_sgn     : a_rd.sgn;
    p1_d.lsc   = a_hi ? in_scale   : a_rd.scale;
    p1_d.lm    = a_hi ? b_m        : a_m;
    p1_d.inf   = a_rd.inf | in_inf;
    p1_d.trunc = a_rd.trunc;
  end

  // S1: align the smaller operand; bits falling off the end are lost precision.
  // A negative distance only arises when lo is zero, so full shift is harmless.
  always_comb begin
    d_s = {p1_q.hsc[SBITS-1], p1_q.hsc} - {p1_q.lsc[SBITS-1], p1_q.lsc};
    if ((d_s < 0) || (d_s > MW)) shamt = MW;
    else                         shamt = int'(d_s);
    wide       = {p1_q.lm, {MW{1'b0}}} >> shamt;
    p2_d       = '0;
    p2_d.v     = p1_q.v;
    p2_d.chan  = p1_q.chan;
    p2_d.last  = p1_q.last;
    p2_d.hs    = p1_q.hs;
    p2_d.ls    = p1_q.ls;
    p2_d.hsc   = p1_q.hsc;
    p2_d.hm    = p1_q.hm;
    p2_d.lm    = wide[2*MW-1:MW];
    p2_d.inf   = p1_q.inf;
    p2_d.trunc = p1_q.trunc | (|wide[MW-1:0]);
  end

  // S2: magnitude add or subtract; hi >= lo so the difference is never negative.
  always_comb begin
    p3_d       = '0;
    p3_d.v     = p2_q.v;
    p3_d.chan  = p2_q.chan;
    p3_d.last  = p2_q.last;
    p3_d.sgn   = p2_q.hs;
    p3_d.sc    = p2_q.hsc;
    p3_d.sum   = (p2_q.hs == p2_q.ls) ? ({1'b0, p2_q.hm} + {1'b0, p2_q.lm})
                                      : ({1'b0, p2_q.hm} - {1'b0, p2_q.lm});
    p3_d.inf   = p2_q.inf;
    p3_d.trunc = p2_q.trunc;
  end

  // S3: leading-one detect, normalise, and clamp the scale range.
  always_comb begin
    lz    = 0;
    found = 1'b0;
    for (int i = SW - 2; i >= 0; i--) begin
      if (!found && p3_q.sum[i]) begin
        lz    = SW - 2 - i;
        found = 1'b1;
      end
    end
    nf        = '0;
    ntr       = 1'b0;
    nsc       = int'($signed(p3_q.sc));
    res       = ACC_ZERO;
    res.inf   = p3_q.inf;
    res.trunc = p3_q.trunc;
    if (p3_q.sum != '0) begin
      if (p3_q.sum[SW-1]) begin
        res.frac = p3_q.sum[SW-2:3];
        ntr      = |p3_q.sum[2:0];
        nsc      = nsc + 1;
      end else begin
        // The leading one is shifted out of the top; it is the hidden bit.
        nf       = p3_q.sum[SW-3:0] << lz;
        res.frac = nf[MW-2:2];
        ntr      = |nf[1:0];
        nsc      = nsc - lz;
      end
      if (nsc > SMAX) begin
        res.zero  = 1'b0;
        res.sgn   = p3_q.sgn;
        res.scale = SBITS'(SMAX);
        res.frac  = '1;
        res.trunc = 1'b1;
      end else if (nsc < -SMAX) begin
        res.frac  = '0;
        res.trunc = 1'b1;
      end else begin
        res.zero  = 1'b0;
        res.sgn   = p3_q.sgn;
        res.scale = nsc[SBITS-1:0];
        res.trunc = p3_q.trunc | ntr;
      end
    end
  end

  // Pipeline registers, per-channel write-back and the result strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= ACC_ZERO;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= OW'(1);
      out_trunc_q <= 1'b0;
    end else begin
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      out_valid_q <= 1'b0;
      if (p3_q.v) begin
        if (p3_q.last) begin
          acc_q[p3_q.chan] <= ACC_ZERO;
          out_valid_q      <= 1'b1;
          out_chan_q       <= p3_q.chan;
          out_data_q       <= {res.sgn, res.scale, res.frac, res.inf, res.zero};
          out_trunc_q      <= res.trunc;
        end else begin
          acc_q[p3_q.chan] <= res;
        end
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_chan      = out_chan_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_truncated = out_trunc_q;
endmodule

// File: tb/tb_positaccum_raw_mc.sv
module tb_positaccum_raw_mc;
  localparam int SBITS = 9;
  localparam int FI    = 56;
  localparam int FA    = 120;
  localparam int CH    = 4;
  localparam int CW    = 2;
  localparam int IW    = SBITS + FI + 3;
  localparam int OW    = SBITS + FA + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  positaccum_raw_mc_if #(.SBITS(SBITS), .FBITS_IN(FI), .FBITS_ACC(FA), .CHANNELS(CH)) bus();

  positaccum_raw_mc #(.SBITS(SBITS), .FBITS_IN(FI), .FBITS_ACC(FA), .CHANNELS(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            chan;
    logic [OW-1:0] data;
    logic [OW-1:0] mask;
    logic          trunc;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input bit s, input int sc, input logic [FI-1:0] f,
                                        input bit inf, input bit z);
    return {s, sc[SBITS-1:0], f, inf, z};
  endfunction

  function automatic logic [OW-1:0] rs(input bit s, input int sc, input logic [FA-1:0] f,
                                        input bit inf, input bit z);
    return {s, sc[SBITS-1:0], f, inf, z};
  endfunction

  // Scoreboard monitor: every result strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got out_valid=1 chan %0d, required no result", bus.out_chan);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_chan", bus.out_chan, mon_e.chan);
        chk("out_data", bus.out_data & mon_e.mask, mon_e.data & mon_e.mask);
        chk("out_truncated", bus.out_truncated, mon_e.trunc);
        chk("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic issue(input int c, input bit last, input logic [IW-1:0] d, input bit push,
                       input logic [OW-1:0] ed, input logic [OW-1:0] em, input bit et,
                       output int stalls);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_chan  = c[CW-1:0];
    bus.in_last  = last;
    bus.in_data  = d;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      stalls++;
      if (stalls > 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: chan %0d waited %0d cycles, required acceptance", c, stalls);
        break;
      end
    end
    if (push && bus.in_ready) begin
      e.chan  = c;
      e.data  = ed;
      e.mask  = em;
      e.trunc = et;
      e.cyc   = cyc + 4;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic beat(input int c, input logic [IW-1:0] d, output int stalls);
    issue(c, 1'b0, d, 1'b0, '0, '0, 1'b0, stalls);
  endtask

  task automatic fin(input int c, input logic [IW-1:0] d, input logic [OW-1:0] ed,
                     input bit et, output int stalls);
    issue(c, 1'b1, d, 1'b1, ed, '1, et, stalls);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() > 0; i++) @(posedge clk);
  endtask

  logic [IW-1:0] ONE, ONE_5, NEG_ONE, NEG_ONE_5, TINY, BIG, INF_IN;
  logic [FA-1:0] F_MSB;
  int st;

  initial begin
    ONE       = mk(0, 0, '0, 0, 0);
    ONE_5     = mk(0, 0, {1'b1, {(FI-1){1'b0}}}, 0, 0);
    NEG_ONE   = mk(1, 0, '0, 0, 0);
    NEG_ONE_5 = mk(1, 0, {1'b1, {(FI-1){1'b0}}}, 0, 0);
    TINY      = mk(0, -200, '0, 0, 0);
    BIG       = mk(0, 255, '0, 0, 0);
    INF_IN    = mk(0, 0, '0, 1, 0);
    F_MSB     = {1'b1, {(FA-1){1'b0}}};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_chan  = '0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_chan", bus.out_chan, 0);
    chk("rst_out_data", bus.out_data, 1);
    chk("rst_out_truncated", bus.out_truncated, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1.0 + 1.0 = 2.0
    beat(0, ONE, st);
    fin(0, ONE, rs(0, 1, '0, 0, 0), 0, st);
    // 1.5 - 1.5 = exact zero
    beat(1, ONE_5, st);
    fin(1, NEG_ONE_5, rs(0, 0, '0, 0, 1), 0, st);
    // back-to-back same channel: three-cycle stalls, 3.0
    beat(2, ONE, st);
    chk("ch2_first_stall", st, 0);
    beat(2, ONE, st);
    chk("ch2_second_stall", st, 3);
    fin(2, ONE, rs(0, 1, F_MSB, 0, 0), 0, st);
    chk("ch2_third_stall", st, 3);

    repeat (5) @(posedge clk);
    #1;
    // round robin over all channels, never stalls, each sums to 4.0
    for (int i = 0; i < 16; i++) begin
      issue(i % 4, i >= 12, ONE, i >= 12, rs(0, 2, '0, 0, 0), '1, 1'b0, st);
      chk("rr_no_stall", st, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    // tiny addend is shifted out entirely
    beat(3, ONE, st);
    fin(3, TINY, rs(0, 0, '0, 0, 0), 1, st);
    // negative result keeps the sign of the larger operand
    beat(2, NEG_ONE, st);
    fin(2, NEG_ONE, rs(1, 1, '0, 0, 0), 0, st);
    // partial cancellation needs a left normalisation: 1.5 - 1.0 = 0.5
    beat(0, ONE_5, st);
    fin(0, NEG_ONE, rs(0, -1, '0, 0, 0), 0, st);
    // scale overflow saturates and flags truncation
    beat(1, BIG, st);
    fin(1, BIG, rs(0, 255, '1, 0, 0), 1, st);
    // inf is sticky; only the inf bit is defined
    beat(3, ONE, st);
    issue(3, 1'b1, INF_IN, 1'b1, rs(0, 0, '0, 1, 0), OW'(2), 1'b0, st);
    // channel is clean again after an inf result
    fin(3, ONE, rs(0, 0, '0, 0, 0), 0, st);

    drain();
    // reset while a last beat is in flight: no result may ever appear
    beat(0, ONE, st);
    issue(0, 1'b1, ONE, 1'b0, '0, '0, 1'b0, st);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_out_data", bus.out_data, 1);
    chk("post_rst_in_ready", bus.in_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    fin(0, ONE, rs(0, 0, '0, 0, 0), 0, st);

    drain();
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
